// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
//   Shared definitions for the reset sequencer: FSM state encoding,
//   minimum legal values for the block parameters and a small helper
//   used when sizing counters at elaboration time.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_SEQ    = 2'd1,
    ST_DONE   = 2'd2,
    ST_SWHOLD = 2'd3
  } rst_state_e;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_NUM_OUT     = 1;
  localparam int MIN_GAP_CYC     = 1;
  localparam int MIN_SW_HOLD_CYC = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain
//   Asynchronous-assert / synchronous-release reset synchroniser.
//   The whole chain clears immediately when async_rst_n falls; after
//   async_rst_n rises a '1' ripples through, so sync_rst_n goes high on
//   the STAGES-th rising edge of clk.
// Ports
//   clk          in   sampling clock, rising edge
//   async_rst_n  in   asynchronous active-low reset
//   sync_rst_n   out  synchronised release (registered)
module rst_sync_chain
  import rst_seq_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_rst_n,
  output logic sync_rst_n
);

  generate
    if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
      $error("rst_sync_chain: STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
  endgenerate

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = chain[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Releases NUM_OUT active-low reset channels one after another,
//   GAP_CYC clk cycles apart, after the asynchronous reset has been
//   synchronised. A software request taken while fully released pulls
//   every channel low again for SW_HOLD_CYC cycles and then re-runs the
//   release sequence. Every output comes straight from a flop.
// Ports
//   clk          in   single clock, rising edge
//   async_rst_n  in   asynchronous active-low reset (immediate assert,
//                     synchronised release)
//   sw_rst_req   in   software reset request, honoured only in ST_DONE
//   rst_n_out    out  [NUM_OUT] per-channel active-low resets, bit 0 first
//   rst_done     out  high once every channel is released
//   busy         out  high whenever the FSM is not in ST_DONE
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 4,
  parameter int GAP_CYC     = 8,
  parameter int SW_HOLD_CYC = 4
) (
  input  logic               clk,
  input  logic               async_rst_n,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               rst_done,
  output logic               busy
);

  generate
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
      $error("rst_sequencer: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
    if (NUM_OUT < MIN_NUM_OUT) begin : g_bad_num_out
      $error("rst_sequencer: NUM_OUT must be >= %0d", MIN_NUM_OUT);
    end
    if (GAP_CYC < MIN_GAP_CYC) begin : g_bad_gap
      $error("rst_sequencer: GAP_CYC must be >= %0d", MIN_GAP_CYC);
    end
    if (SW_HOLD_CYC < MIN_SW_HOLD_CYC) begin : g_bad_hold
      $error("rst_sequencer: SW_HOLD_CYC must be >= %0d", MIN_SW_HOLD_CYC);
    end
  endgenerate

  localparam int CNT_W = $clog2(max_int(GAP_CYC, SW_HOLD_CYC) + 1);
  localparam int IDX_W = max_int(1, $clog2(NUM_OUT));

  // Terminal counts: the counter holds "edges elapsed - 1", so the
  // release happens on the edge where it already sits at N-1.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

  logic sync_rel;

  rst_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .sync_rst_n  (sync_rel)
  );

  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [IDX_W-1:0]   idx_inc;
  logic [NUM_OUT-1:0] out_q,   out_d;
  logic               done_q,  done_d;
  logic               busy_q,  busy_d;

  // idx_q is the most recently released channel.
  assign idx_inc = idx_q + 1'b1;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Output flops are loaded from next-state values so each output
  // changes on the same edge as the state transition that causes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    done_d  = done_q;

    unique case (state_q)
      ST_RST: begin
        if (sync_rel) begin
          cnt_d    = '0;
          idx_d    = '0;
          out_d    = '0;
          out_d[0] = 1'b1;
          if (NUM_OUT == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SEQ;
          end
        end
      end

      ST_SEQ: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d          = '0;
          idx_d          = idx_inc;
          out_d[idx_inc] = 1'b1;
          if (idx_inc == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (sw_rst_req) begin
          state_d = ST_SWHOLD;
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = '0;
          done_d  = 1'b0;
        end
      end

      ST_SWHOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d    = '0;
          idx_d    = '0;
          out_d[0] = 1'b1;
          if (NUM_OUT == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SEQ;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_RST;
      end
    endcase

    busy_d = (state_d != ST_DONE);
  end

  assign rst_n_out = out_q;
  assign rst_done  = done_q;
  assign busy      = busy_q;

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of release-synchroniser flops (legal range >=2).
REQ-002 The block SHALL have parameter NUM_OUT, default 4, giving the number of sequenced reset outputs (legal range >=1).
REQ-003 The block SHALL have parameter GAP_CYC, default 8, giving the clk cycles between consecutive output releases (legal range >=1).
REQ-004 The block SHALL have parameter SW_HOLD_CYC, default 4, giving the clk cycles all outputs stay low after a software reset (legal range >=1).
REQ-005 The block SHALL use a single clock and an asynchronous active-low reset: clk, input, 1, the only clock, rising edge.
REQ-006 The reset port SHALL be async_rst_n, input, 1, asynchronous active-low reset; assertion takes effect immediately, release is synchronised.
REQ-007 The block SHALL have sw_rst_req, input, 1, synchronous software reset request, sampled on the rising edge of clk.
REQ-008 The block SHALL have rst_n_out, output, NUM_OUT, per-channel active-low resets; bit 0 is released first.
REQ-009 The block SHALL have rst_done, output, 1, high when all channels are released.
REQ-010 The block SHALL have busy, output, 1, high whenever the FSM is not in ST_DONE.

Function
REQ-011 Asserting async_rst_n low SHALL drive all rst_n_out bits and rst_done low with no clock edge required, even for a pulse shorter than one clk period.
REQ-012 Release SHALL pass through a SYNC_STAGES-deep chain cleared by async_rst_n; the synchronised release goes high on the SYNC_STAGES-th rising edge after async_rst_n rises.
REQ-013 The FSM SHALL have four states: ST_RST, ST_SEQ, ST_DONE and ST_SWHOLD.
REQ-014 ST_RST SHALL move to ST_SEQ on the first edge where the synchronised release is high; on that edge rst_n_out[0] goes high.
REQ-015 In ST_SEQ, rst_n_out[i] SHALL go high exactly GAP_CYC edges after rst_n_out[i-1]; after async release, bit i rises on edge SYNC_STAGES+1+i*GAP_CYC.
REQ-016 Once released, an output bit SHALL stay high until the next async reset or software reset.
REQ-017 rst_done SHALL rise on the same edge as rst_n_out[NUM_OUT-1], and the FSM SHALL enter ST_DONE on that edge.
REQ-018 With NUM_OUT=1, rst_done and rst_n_out[0] SHALL rise together.
REQ-019 If sw_rst_req is sampled high in ST_DONE, then on that edge all rst_n_out bits and rst_done SHALL go low and the FSM SHALL enter ST_SWHOLD.
REQ-020 ST_SWHOLD SHALL hold for SW_HOLD_CYC edges; on the SW_HOLD_CYC-th edge after the sampling edge, rst_n_out[0] goes high and the FSM enters ST_SEQ, with later bits following per REQ-015.
REQ-021 sw_rst_req SHALL be ignored in ST_RST, ST_SEQ and ST_SWHOLD, with no queuing.
REQ-022 sw_rst_req held high continuously SHALL retrigger a software reset on each entry to ST_DONE.
REQ-023 The gap counter SHALL be $clog2(max(GAP_CYC,SW_HOLD_CYC)+1) bits wide, and the channel index SHALL be max(1,$clog2(NUM_OUT)) bits wide.
REQ-024 Neither counter SHALL wrap past its terminal value.
REQ-025 async_rst_n asserted in any state, including mid-sequence or mid-hold, SHALL override all other behaviour per REQ-011, and a full sequence SHALL restart from REQ-012 on release.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 While async_rst_n is low: rst_n_out = 0, rst_done = 0, busy = 1, state = ST_RST, the synchroniser chain is all zeros, and the counters are 0.

Structure
REQ-028 Package rst_seq_pkg SHALL hold the FSM state enum (ST_RST, ST_SEQ, ST_DONE, ST_SWHOLD) and the parameter minimum-value constants.
REQ-029 Sub-module rst_sync_chain SHALL implement the SYNC_STAGES async-clear synchroniser, instantiated once.
REQ-030 Illegal parameter values SHALL trigger an elaboration-time error.

Verification
All scenarios use clk 10 ns and defaults SYNC_STAGES=2, NUM_OUT=4, GAP_CYC=8, SW_HOLD_CYC=4, unless stated.
REQ-031 async_rst_n released at 23 ns (between edges) -> rst_n_out bits 0..3 rise on edges 3, 11, 19, 27 after release; rst_done and busy=0 on edge 27.
REQ-032 async_rst_n pulled low 3 ns after an edge in ST_DONE -> rst_n_out=4'b0000 and rst_done=0 within 1 ns, before the next edge.
REQ-033 One-cycle sw_rst_req in ST_DONE -> all outputs low on the sampling edge; bits 0..3 rise on edges +4, +12, +20, +28.
REQ-034 sw_rst_req pulsed while rst_n_out=4'b0011 (ST_SEQ) -> no effect, and the sequence completes on schedule.
REQ-035 async_rst_n low for 2 ns mid-sequence (rst_n_out=4'b0001) -> all outputs immediately 0, then a full restart per REQ-031 timing from the release.
REQ-036 NUM_OUT=1, SYNC_STAGES=3 -> rst_n_out[0] and rst_done rise together on edge 4 after release.
